// File: rtl/uart_receiver_if.sv
// uart_receiver_if: serial input and received-byte outputs of the UART receiver.
interface uart_receiver_if;
    logic       RxD;
    logic       Rx_sample_ENABLE;
    logic [7:0] Rx_DATA;
    logic       Rx_VALID;
    logic       Rx_PERROR;
    logic       Rx_FERROR;
    logic       Rx_BUSY;
    modport master (output RxD, Rx_sample_ENABLE, input Rx_DATA, Rx_VALID, Rx_PERROR, Rx_FERROR, Rx_BUSY);
    modport slave (input RxD, Rx_sample_ENABLE, output Rx_DATA, Rx_VALID, Rx_PERROR, Rx_FERROR, Rx_BUSY);
endinterface

// File: rtl/uart_receiver.sv
// uart_receiver: 16x-oversampled receiver for start/8 data LSB-first/parity/stop frames.
module uart_receiver #(
    parameter bit PARITY_ODD = 1'b0
) (
    input logic            clk,
    input logic            reset,
    uart_receiver_if.slave rx
);
    localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4;
    logic [2:0] state;
    logic [3:0] tick_cnt;
    logic [2:0] bit_idx;
    logic [7:0] shift;
    logic       par;
    logic       sync1;
    logic       rxd_s;
    logic       perr;
    assign perr = (^shift ^ par) != PARITY_ODD;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            tick_cnt     <= '0;
            bit_idx      <= '0;
            shift        <= '0;
            par          <= 1'b0;
            sync1        <= 1'b1;
            rxd_s        <= 1'b1;
            rx.Rx_DATA   <= '0;
            rx.Rx_VALID  <= 1'b0;
            rx.Rx_PERROR <= 1'b0;
            rx.Rx_FERROR <= 1'b0;
            rx.Rx_BUSY   <= 1'b0;
        end else begin
            {rxd_s, sync1} <= {sync1, rx.RxD};
            rx.Rx_VALID    <= 1'b0;
            if (rx.Rx_sample_ENABLE) begin
                tick_cnt <= tick_cnt + 4'd1;
                case (state)
                    IDLE: begin
                        tick_cnt <= '0;
                        if (!rxd_s) begin
                            state      <= START;
                            rx.Rx_BUSY <= 1'b1;
                        end
                    end
                    // mid start bit: a high line here was only a glitch
                    START: if (tick_cnt == 4'd7) begin
                        tick_cnt   <= '0;
                        bit_idx    <= '0;
                        state      <= rxd_s ? IDLE : DATA;
                        rx.Rx_BUSY <= !rxd_s;
                    end
                    DATA: if (tick_cnt == 4'd15) begin
                        shift[bit_idx] <= rxd_s;
                        bit_idx        <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state <= PARITY;
                    end
                    PARITY: if (tick_cnt == 4'd15) begin
                        par   <= rxd_s;
                        state <= STOP;
                    end
                    STOP: if (tick_cnt == 4'd15) begin
                        state        <= IDLE;
                        rx.Rx_BUSY   <= 1'b0;
                        rx.Rx_DATA   <= shift;
                        rx.Rx_PERROR <= perr;
                        rx.Rx_FERROR <= !rxd_s;
                        rx.Rx_VALID  <= !perr && rxd_s;
                    end
                    default: begin
                        state      <= IDLE;
                        rx.Rx_BUSY <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: drives even- and odd-parity receivers from one serial line.
module tb_uart_receiver;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic line = 1'b1;
    logic en = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   vcnt_e = 0;
    int   vcnt_o = 0;
    int   bad_busy = 0;

    always #5 clk = ~clk;

    uart_receiver_if bus_e();
    uart_receiver_if bus_o();
    assign bus_e.RxD = line;
    assign bus_o.RxD = line;
    assign bus_e.Rx_sample_ENABLE = en;
    assign bus_o.Rx_sample_ENABLE = en;

    uart_receiver #(.PARITY_ODD(1'b0)) dut_e (.clk(clk), .reset(reset), .rx(bus_e));
    uart_receiver #(.PARITY_ODD(1'b1)) dut_o (.clk(clk), .reset(reset), .rx(bus_o));

    // count valid cycles; valid must coincide with busy already low
    always @(negedge clk) begin
        if (bus_e.Rx_VALID) vcnt_e++;
        if (bus_o.Rx_VALID) vcnt_o++;
        if ((bus_e.Rx_VALID && bus_e.Rx_BUSY) || (bus_o.Rx_VALID && bus_o.Rx_BUSY)) bad_busy++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            en = 1'b1;
            @(negedge clk);
            en = 1'b0;
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic stop);
        line = 1'b0;
        ticks(16);
        for (int i = 0; i < 8; i++) begin
            line = d[i];
            ticks(16);
        end
        line = p;
        ticks(16);
        line = stop;
        ticks(16);
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_data_e"}, bus_e.Rx_DATA, 8'h00);
        chk({tag, "_valid_e"}, bus_e.Rx_VALID, 0);
        chk({tag, "_perr_e"}, bus_e.Rx_PERROR, 0);
        chk({tag, "_ferr_e"}, bus_e.Rx_FERROR, 0);
        chk({tag, "_busy_e"}, bus_e.Rx_BUSY, 0);
        chk({tag, "_busy_o"}, bus_o.Rx_BUSY, 0);
    endtask

    typedef struct {
        logic [7:0] d;
        logic       p;
        logic       perr_e;
        logic       perr_o;
        int         val_e;
        int         val_o;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int ve, vo;
        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b1, 1, 0};
        vecs[1] = '{8'h00, 1'b1, 1'b1, 1'b0, 0, 1};
        vecs[2] = '{8'h3C, 1'b0, 1'b0, 1'b1, 1, 0};
        vecs[3] = '{8'h01, 1'b0, 1'b1, 1'b0, 0, 1};
        vecs[4] = '{8'hFF, 1'b1, 1'b1, 1'b0, 0, 1};

        #2 reset = 1'b0;
        #1 chk_cleared("rst_idle");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        ticks(20);
        chk("post_rst_busy", bus_e.Rx_BUSY, 0);

        // frames sent back to back, no idle gap
        foreach (vecs[k]) begin
            ve = vcnt_e;
            vo = vcnt_o;
            send_frame(vecs[k].d, vecs[k].p, 1'b1);
            chk($sformatf("v%0d_data_e", k), bus_e.Rx_DATA, vecs[k].d);
            chk($sformatf("v%0d_data_o", k), bus_o.Rx_DATA, vecs[k].d);
            chk($sformatf("v%0d_perr_e", k), bus_e.Rx_PERROR, vecs[k].perr_e);
            chk($sformatf("v%0d_perr_o", k), bus_o.Rx_PERROR, vecs[k].perr_o);
            chk($sformatf("v%0d_ferr_e", k), bus_e.Rx_FERROR, 0);
            chk($sformatf("v%0d_valid_e", k), vcnt_e - ve, vecs[k].val_e);
            chk($sformatf("v%0d_valid_o", k), vcnt_o - vo, vecs[k].val_o);
            chk($sformatf("v%0d_busy_e", k), bus_e.Rx_BUSY, 0);
        end

        // framing error, line left low: break re-triggers START
        ve = vcnt_e;
        vo = vcnt_o;
        send_frame(8'h81, 1'b0, 1'b0);
        chk("fe_data", bus_e.Rx_DATA, 8'h81);
        chk("fe_ferr_e", bus_e.Rx_FERROR, 1);
        chk("fe_ferr_o", bus_o.Rx_FERROR, 1);
        chk("fe_perr_e", bus_e.Rx_PERROR, 0);
        chk("fe_perr_o", bus_o.Rx_PERROR, 1);
        chk("fe_valid", (vcnt_e - ve) + (vcnt_o - vo), 0);
        chk("fe_restart_busy", bus_e.Rx_BUSY, 1);
        line = 1'b1;
        ticks(8);
        chk("fe_recover_busy", bus_e.Rx_BUSY, 0);

        // false start: 4 low ticks
        line = 1'b0;
        ticks(4);
        chk("fs_busy_hi", bus_e.Rx_BUSY, 1);
        line = 1'b1;
        ticks(6);
        chk("fs_busy_lo", bus_e.Rx_BUSY, 0);
        chk("fs_data_hold", bus_e.Rx_DATA, 8'h81);
        chk("fs_ferr_hold", bus_e.Rx_FERROR, 1);
        chk("fs_valid", vcnt_e - ve, 0);

        // enable held low freezes the FSM
        line = 1'b0;
        repeat (60) @(negedge clk);
        chk("freeze_busy", bus_e.Rx_BUSY, 0);
        line = 1'b1;
        repeat (4) @(negedge clk);

        // good frame clears the framing flag
        ve = vcnt_e;
        send_frame(8'h3C, 1'b0, 1'b1);
        chk("ok_ferr", bus_e.Rx_FERROR, 0);
        chk("ok_valid", vcnt_e - ve, 1);

        // reset in the middle of DATA
        line = 1'b0;
        ticks(40);
        chk("mid_busy", bus_e.Rx_BUSY, 1);
        reset = 1'b0;
        #1 chk_cleared("rst_mid");
        @(negedge clk);
        reset = 1'b1;
        line = 1'b1;
        ticks(20);
        chk("rst_mid_after_busy", bus_e.Rx_BUSY, 0);
        chk("valid_busy_overlap", bad_busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Receive-side counterpart of the UART transmit stage; the link partner's TxD drives this block's RxD.
- Deserialises the same 11-bit frame format the transmitter emits: start (0), 8 data bits LSB first, parity, stop (1).
- Timing comes from a 16x-oversampling enable supplied by the baud controller.
- Delivers the data byte, a one-cycle valid strobe, and parity/framing error flags to the consumer.

Parameters:
PARITY_ODD, 0, 0 = even parity (parity bit makes total ones in data+parity even), 1 = odd parity

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
RxD  input  1  serial line, asynchronous to clk, idles high
Rx_sample_ENABLE  input  1  one-clk pulse at 16x baud rate, synchronous to clk
Rx_DATA  output  8  last received byte
Rx_VALID  output  1  one-clk pulse: error-free frame completed
Rx_PERROR  output  1  parity error flag for last completed frame
Rx_FERROR  output  1  framing error flag (stop bit sampled 0) for last completed frame
Rx_BUSY  output  1  high while a frame is in progress

Behaviour:
- Reset (reset=0, async): state=IDLE; counters 0; synchroniser flops=1; Rx_DATA=8'h00; Rx_VALID, Rx_PERROR, Rx_FERROR, Rx_BUSY=0. Reset mid-frame aborts the frame with no output update.
- RxD passes through a 2-flop synchroniser (reset value 1). All sampling uses the synchronised value rxd_s.
- Counters: tick_cnt is 4 bits; bit_idx is 3 bits. Both advance only on clk edges where Rx_SAMPLE_ENABLE=1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - On a tick with rxd_s=0: go to START, tick_cnt=0.
  - Otherwise stay in IDLE.
- START:
  - Each tick increments tick_cnt.
  - On the tick where tick_cnt==7 (mid start bit):
    - rxd_s=0: go to DATA, tick_cnt=0, bit_idx=0.
    - rxd_s=1 (glitch / false start): return to IDLE with no output change.
- DATA:
  - Each tick increments tick_cnt (wraps 15->0).
  - On the tick where tick_cnt==15: shift rxd_s into bit position bit_idx (LSB first), then bit_idx++.
  - After the sample with bit_idx==7: go to PARITY.
- PARITY: on the tick where tick_cnt==15, capture the parity bit and go to STOP.
- STOP: on the tick where tick_cnt==15, complete the frame and go to IDLE. On the same clk edge:
  - Rx_DATA <= assembled byte (updated even on error).
  - Rx_PERROR <= (XOR of data bits ^ parity bit) != PARITY_ODD.
  - Rx_FERROR <= (rxd_s==0).
  - Rx_VALID <= 1 for exactly one clk, only if both errors are 0.
- Flag persistence: error flags and Rx_DATA hold until the next frame completion. They are not cleared by a new start.
- Rx_BUSY = 1 in every state except IDLE; registered, and changes on the same edge as the state.
- A framing error leaves the FSM in IDLE. A line still low re-triggers START on the next tick (break condition yields repeated FERROR frames).
- Back-to-back frames: the FSM accepts a new start on the first tick after returning to IDLE. No idle gap is required beyond the stop bit's remaining half-bit.
- Rx_sample_ENABLE held low freezes the FSM and counters; no timeout.
- Latency: Rx_VALID asserts 2 clk (synchroniser) plus at most 1 tick after the mid-point of the stop bit.

Test Plan:
- Reset: assert reset=0 mid-idle and mid-DATA -> all outputs 0, Rx_BUSY=0 immediately (no clk needed); after release, line idle -> Rx_BUSY stays 0.
- Good frame, even parity: send 0xA5 with parity 0, stop 1 at 16 ticks/bit -> Rx_DATA=8'hA5, Rx_VALID high exactly 1 clk, Rx_PERROR=0, Rx_FERROR=0, Rx_BUSY falls on the same edge.
- Parity error: send 0x00 with parity 1 -> Rx_DATA=8'h00, Rx_PERROR=1, Rx_VALID never asserts. Next good frame 0x3C (parity 0) -> Rx_PERROR returns to 0, Rx_VALID pulses.
- Framing error: send 0x81 (parity 0) with stop bit 0 -> Rx_FERROR=1, Rx_DATA=8'h81, no Rx_VALID. Line held low afterwards -> START re-entered, Rx_BUSY=1.
- False start: pull RxD low for 4 ticks then high -> Rx_BUSY pulses high then returns to IDLE before the 8th tick; outputs unchanged.
- Back-to-back and odd parity: PARITY_ODD=1, send 0x01 (parity 0) then 0xFF (parity 1) with no idle gap -> two Rx_VALID pulses, Rx_DATA=8'h01 then 8'hFF, no errors.
